hazard_sequencer: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Decides each cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or take a bubble.
- Handles three cases: load-use hazards, taken-branch flushes in ID, and variable-latency data-memory waits.
- Tracks memory-wait time with a timeout FSM and keeps saturating stall/flush performance counters.

---
 rtl/hazard_sequencer_if.sv | 43 ++++
 rtl/hazard_sequencer.sv | 149 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard-sequencer bundle: hazard facts from ID/EX/MEM in,
// per-stage advance/hold/bubble controls and status out.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             branch_taken_i;
    logic             ex_mem_read_i;
    logic [4:0]       ex_rt_i;
    logic             mem_access_i;
    logic             dmem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_write_o;
    logic             idex_bubble_o;
    logic             exmem_write_o;
    logic             memwb_bubble_o;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, branch_taken_i,
        output ex_mem_read_i, ex_rt_i, mem_access_i, dmem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o,
        input  idex_write_o, idex_bubble_o, exmem_write_o,
        input  memwb_bubble_o, busy_o, err_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, branch_taken_i,
        input  ex_mem_read_i, ex_rt_i, mem_access_i, dmem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o,
        output idex_write_o, idex_bubble_o, exmem_write_o,
        output memwb_bubble_o, busy_o, err_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller: load-use, branch flush and
// data-memory wait with timeout, plus saturating perf counters.
module hazard_sequencer #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hazard_sequencer_if.slave   hz
);
    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    logic memstall, loaduse, freeze, lu_hit, br_hit;
    logic pc_we, ifid_we, ifid_fl, idex_we, idex_bub;
    logic exmem_we, memwb_bub, busy;

    assign memstall = hz.mem_access_i & ~hz.dmem_ready_i;
    assign loaduse  = hz.ex_mem_read_i & (hz.ex_rt_i != 5'd0)
                    & ((hz.ex_rt_i == hz.id_rs_i)
                    | (hz.id_uses_rt_i & (hz.ex_rt_i == hz.id_rt_i)));

    // Mutually exclusive qualifiers encode the priority order.
    assign freeze = (state_q == S_ERROR) | memstall;
    assign lu_hit = ~freeze & loaduse;
    assign br_hit = ~freeze & ~loaduse & hz.branch_taken_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            S_RUN: begin
                if (memstall) begin
                    state_d = S_WAIT;
                    wait_d  = WCW'(1);
                end
            end
            S_WAIT: begin
                if (memstall) begin
                    if (wait_q == WCW'(MAX_WAIT - 1)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WCW'(1);
                    end
                end else begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        ifid_fl   = 1'b0;
        idex_we   = 1'b1;
        idex_bub  = 1'b0;
        exmem_we  = 1'b1;
        memwb_bub = 1'b0;
        busy      = (state_q == S_WAIT);
        unique case (1'b1)
            freeze: begin
                pc_we     = 1'b0;
                ifid_we   = 1'b0;
                idex_we   = 1'b0;
                exmem_we  = 1'b0;
                memwb_bub = 1'b1;
            end
            lu_hit: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_bub = 1'b1;
            end
            br_hit: begin
                ifid_fl = 1'b1;
            end
            default: begin
                pc_we = 1'b1;
            end
        endcase
        // Held reset drains the pipe: nothing loads, bubbles go in.
        if (!rst_i) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            ifid_fl   = 1'b0;
            idex_we   = 1'b0;
            idex_bub  = 1'b1;
            exmem_we  = 1'b0;
            memwb_bub = 1'b1;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((freeze | lu_hit) && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + CNT_W'(1);
            if (br_hit && (flush_q != {CNT_W{1'b1}}))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.pc_write_o     = pc_we;
    assign hz.ifid_write_o   = ifid_we;
    assign hz.ifid_flush_o   = ifid_fl;
    assign hz.idex_write_o   = idex_we;
    assign hz.idex_bubble_o  = idex_bub;
    assign hz.exmem_write_o  = exmem_we;
    assign hz.memwb_bubble_o = memwb_bub;
    assign hz.busy_o         = busy;
    assign hz.err_o          = err_q;
    assign hz.stall_cnt_o    = stall_q;
    assign hz.flush_cnt_o    = flush_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed plan steps plus random
// traffic against a cycle-level behavioural model.
module tb_hazard_sequencer;
    localparam int MAX_WAIT = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    hazard_sequencer_if #(.CNT_W(16)) hz ();
    hazard_sequencer_if #(.CNT_W(4))  hs ();

    hazard_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz.slave)
    );

    hazard_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hs.slave)
    );

    logic [4:0] rs, rt, ext;
    logic       use_rt, br, mrd, macc, rdy;

    assign hz.id_rs_i = rs;        assign hs.id_rs_i = rs;
    assign hz.id_rt_i = rt;        assign hs.id_rt_i = rt;
    assign hz.id_uses_rt_i = use_rt; assign hs.id_uses_rt_i = use_rt;
    assign hz.branch_taken_i = br; assign hs.branch_taken_i = br;
    assign hz.ex_mem_read_i = mrd; assign hs.ex_mem_read_i = mrd;
    assign hz.ex_rt_i = ext;       assign hs.ex_rt_i = ext;
    assign hz.mem_access_i = macc; assign hs.mem_access_i = macc;
    assign hz.dmem_ready_i = rdy;  assign hs.dmem_ready_i = rdy;

    // Model: length of the current memory-stall streak, error flag,
    // and unbounded event tallies (saturation applied on compare).
    int m_wait, m_stall, m_flush;
    bit m_err;
    int n_vec, n_err;

    function automatic int sat(int v, int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    function automatic bit is_ms();
        return macc && !rdy;
    endfunction

    function automatic bit is_lu();
        return mrd && (ext != 0) &&
               ((ext == rs) || (use_rt && (ext == rt)));
    endfunction

    // {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, memwb_bub, busy, err}
    function automatic logic [8:0] exp_ctrl();
        logic b, e;
        if (!rst_i) return 9'b000010100;
        e = m_err;
        b = !m_err && (m_wait > 0);
        if (m_err || is_ms()) return {7'b0000001, b, e};
        if (is_lu())          return {7'b0001110, b, e};
        if (br)               return {7'b1111010, b, e};
        return {7'b1101010, b, e};
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o,
                hz.idex_write_o, hz.idex_bubble_o, hz.exmem_write_o,
                hz.memwb_bubble_o, hz.busy_o, hz.err_o};
    endfunction

    function automatic logic [8:0] dut4_ctrl();
        return {hs.pc_write_o, hs.ifid_write_o, hs.ifid_flush_o,
                hs.idex_write_o, hs.idex_bubble_o, hs.exmem_write_o,
                hs.memwb_bubble_o, hs.busy_o, hs.err_o};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctrl"},   16'(dut_ctrl()),   16'(exp_ctrl()));
        check({tag, ".ctrl4"},  16'(dut4_ctrl()),  16'(exp_ctrl()));
        check({tag, ".stall"},  hz.stall_cnt_o,    16'(sat(m_stall, 16)));
        check({tag, ".flush"},  hz.flush_cnt_o,    16'(sat(m_flush, 16)));
        check({tag, ".stall4"}, 16'(hs.stall_cnt_o), 16'(sat(m_stall, 4)));
        check({tag, ".flush4"}, 16'(hs.flush_cnt_o), 16'(sat(m_flush, 4)));
    endtask

    task automatic drive(input logic [4:0] a_rs, a_rt, a_ext,
                         input logic a_use, a_br, a_mrd, a_macc, a_rdy);
        rs = a_rs; rt = a_rt; ext = a_ext; use_rt = a_use;
        br = a_br; mrd = a_mrd; macc = a_macc; rdy = a_rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Check mid-cycle, then advance the model on the clock edge.
    task automatic step(input string tag);
        @(negedge clk_i);
        check_all(tag);
        @(posedge clk_i);
        if (m_err) begin
            m_stall++;
        end else if (is_ms()) begin
            m_stall++;
            m_wait++;
            if (m_wait == MAX_WAIT) m_err = 1'b1;
        end else begin
            m_wait = 0;
            if (is_lu())  m_stall++;
            else if (br)  m_flush++;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_i = 1'b0;
        m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        #1;
        check_all(tag);
        idle();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        idle();
        #1;
        check_all("por");
        do_reset("rst0");
        step("idle");

        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lu_rs");
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lu_zero");
        drive(5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lu_rt");
        drive(5'd3, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("lu_rt_unused");
        check("lu.stall_cnt", hz.stall_cnt_o, 16'd2);

        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lu_br");
        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("br");
        idle();
        step("br_after");
        check("br.flush_cnt", hz.flush_cnt_o, 16'd1);

        do_reset("rst1");
        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step("memwait");
        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("mem_release");
        idle();
        step("mem_after");
        check("mem.stall_cnt", hz.stall_cnt_o, 16'd4);
        check("mem.busy", 16'(hz.busy_o), 16'd0);

        do_reset("rst2");
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (18) step("timeout");
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) step("error_hold");
        check("err.flag", 16'(hz.err_o), 16'd1);
        do_reset("rst_err");
        check("err.cleared", 16'(hz.err_o), 16'd0);

        drive(5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (20) step("sat");
        idle();
        step("sat_after");
        check("sat.stall4", 16'(hs.stall_cnt_o), 16'd15);
        check("sat.stall16", hz.stall_cnt_o, 16'd20);

        do_reset("rst3");
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 9) < 6));
            step("rand");
            if (i == 200) do_reset("rst_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
